// File: rtl/fib_if.sv
// Control/status bundle for the Fibonacci sequencer: seed loads, run control,
// pacing selection, random-access term read and run status.
interface fib_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             load_a;
  logic             load_b;
  logic [WIDTH-1:0] seed;
  logic             start;
  logic             step_mode;
  logic             step;
  logic             saturate;
  logic [AW-1:0]    read_addr;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] current;
  logic [AW-1:0]    index;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output load_a, load_b, seed, start, step_mode, step, saturate, read_addr,
    input  read_data, current, index, busy, done, overflow
  );

  modport slave (
    input  load_a, load_b, seed, start, step_mode, step, saturate, read_addr,
    output read_data, current, index, busy, done, overflow
  );
endinterface

// File: rtl/fib_sequencer.sv
// Fibonacci-style term generator: two switch-loaded seeds, terms 2..DEPTH-1
// computed one per step (divider- or manually-paced), with overflow tracking.
module fib_sequencer #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 30000000
) (
  input logic  clk,
  input logic  rst_n,
  fib_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] TICK_LAST = DW'(TICK_DIV - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] term [DEPTH];
  logic [WIDTH-1:0] cur_q;
  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    nxt_q;
  logic [DW-1:0]    div_q;
  logic             ovf_q;

  logic             load;
  logic             step_ev;
  logic [AW-1:0]    ia, ib;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sum_store;

  function automatic logic [WIDTH-1:0] clamp_sum(input logic [WIDTH:0] s, input logic sat);
    return (s[WIDTH] && sat) ? '1 : s[WIDTH-1:0];
  endfunction

  assign ia        = nxt_q - AW'(1);
  assign ib        = nxt_q - AW'(2);
  assign sum       = {1'b0, term[ia]} + {1'b0, term[ib]};
  assign sum_store = clamp_sum(sum, bus.saturate);

  always_comb begin
    load     = bus.load_a | bus.load_b;
    step_ev  = 1'b0;
    state_nx = state;
    if (state == RUN && !load)
      step_ev = bus.step_mode ? bus.step : (div_q == TICK_LAST);
    if (load) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) state_nx = RUN;
        RUN:        if (step_ev && nxt_q == LAST_IDX) state_nx = DONE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Term storage, divider and run bookkeeping; loads override everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) term[i] <= '0;
      cur_q <= '0;
      idx_q <= '0;
      nxt_q <= AW'(2);
      div_q <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      if (bus.load_a) term[0] <= bus.seed;
      if (bus.load_b) term[1] <= bus.seed;
      cur_q <= bus.seed;
      idx_q <= bus.load_b ? AW'(1) : AW'(0);
      div_q <= '0;
    end else if (bus.start && state != RUN) begin
      nxt_q <= AW'(2);
      div_q <= '0;
      ovf_q <= 1'b0;
    end else if (state == RUN) begin
      if (bus.step_mode || div_q == TICK_LAST) div_q <= '0;
      else                                     div_q <= div_q + DW'(1);
      if (step_ev) begin
        term[nxt_q] <= sum_store;
        cur_q       <= sum_store;
        idx_q       <= nxt_q;
        nxt_q       <= nxt_q + AW'(1);
        if (sum[WIDTH]) ovf_q <= 1'b1;
      end
    end
  end

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  always_comb begin
    bus.read_data = '0;
    if (int'(bus.read_addr) < DEPTH) bus.read_data = term[bus.read_addr];
  end

  assign bus.current  = cur_q;
  assign bus.index    = idx_q;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench: three sequencer instances (16-bit/tick 1, 8-bit/tick 1,
// 16-bit/tick 4) exercised with hand-computed Fibonacci and Lucas values.
module tb_fib_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   n;

  always #5 clk = ~clk;

  fib_if #(.WIDTH(16), .DEPTH(16)) a_if ();
  fib_if #(.WIDTH(8),  .DEPTH(16)) b_if ();
  fib_if #(.WIDTH(16), .DEPTH(16)) c_if ();

  fib_sequencer #(.WIDTH(16), .DEPTH(16), .TICK_DIV(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  fib_sequencer #(.WIDTH(8),  .DEPTH(16), .TICK_DIV(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  fib_sequencer #(.WIDTH(16), .DEPTH(16), .TICK_DIV(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.load_a = 0; a_if.load_b = 0; a_if.seed = '0; a_if.start = 0;
    a_if.step_mode = 0; a_if.step = 0; a_if.saturate = 0; a_if.read_addr = '0;
    b_if.load_a = 0; b_if.load_b = 0; b_if.seed = '0; b_if.start = 0;
    b_if.step_mode = 0; b_if.step = 0; b_if.saturate = 0; b_if.read_addr = '0;
    c_if.load_a = 0; c_if.load_b = 0; c_if.seed = '0; c_if.start = 0;
    c_if.step_mode = 0; c_if.step = 0; c_if.saturate = 0; c_if.read_addr = '0;
    #3;
    chk("rst_current", 32'(a_if.current), 0);
    chk("rst_index",   32'(a_if.index), 0);
    chk("rst_busy",    32'(a_if.busy), 0);
    chk("rst_done",    32'(a_if.done), 0);
    chk("rst_ovf",     32'(a_if.overflow), 0);
    chk("rst_term0",   32'(a_if.read_data), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 16-bit Fibonacci, one step per cycle
    a_if.seed = 16'd0; a_if.load_a = 1; tick();
    a_if.load_a = 0; a_if.seed = 16'd1; a_if.load_b = 1; tick();
    a_if.load_b = 0;
    chk("a_load_cur", 32'(a_if.current), 1);
    chk("a_load_idx", 32'(a_if.index), 1);
    a_if.start = 1; tick();
    a_if.start = 0;
    chk("a_busy", 32'(a_if.busy), 1);
    n = 0;
    while (!a_if.done && n < 40) begin tick(); n++; end
    chk("a_steps", 32'(n), 14);
    chk("a_busy_done", 32'(a_if.busy), 0);
    chk("a_index", 32'(a_if.index), 15);
    chk("a_current", 32'(a_if.current), 610);
    a_if.read_addr = 4'd15; #1;
    chk("a_term15", 32'(a_if.read_data), 610);
    a_if.read_addr = 4'd10; #1;
    chk("a_term10", 32'(a_if.read_data), 55);
    chk("a_ovf", 32'(a_if.overflow), 0);

    // 8-bit wrap
    b_if.seed = 8'd0; b_if.load_a = 1; tick();
    b_if.load_a = 0; b_if.seed = 8'd1; b_if.load_b = 1; tick();
    b_if.load_b = 0; b_if.start = 1; tick();
    b_if.start = 0;
    n = 0;
    while (!b_if.done && n < 40) begin tick(); n++; end
    chk("b_steps", 32'(n), 14);
    b_if.read_addr = 4'd13; #1; chk("b_term13", 32'(b_if.read_data), 233);
    b_if.read_addr = 4'd14; #1; chk("b_term14", 32'(b_if.read_data), 121);
    b_if.read_addr = 4'd15; #1; chk("b_term15", 32'(b_if.read_data), 98);
    chk("b_ovf", 32'(b_if.overflow), 1);

    // 8-bit saturate, restarted straight from DONE
    b_if.saturate = 1; b_if.start = 1; tick();
    b_if.start = 0;
    chk("s_ovf_clr", 32'(b_if.overflow), 0);
    chk("s_busy", 32'(b_if.busy), 1);
    n = 0;
    while (!b_if.done && n < 40) begin tick(); n++; end
    chk("s_steps", 32'(n), 14);
    b_if.read_addr = 4'd13; #1; chk("s_term13", 32'(b_if.read_data), 233);
    b_if.read_addr = 4'd14; #1; chk("s_term14", 32'(b_if.read_data), 255);
    b_if.read_addr = 4'd15; #1; chk("s_term15", 32'(b_if.read_data), 255);
    chk("s_ovf", 32'(b_if.overflow), 1);

    // Lucas seeds, divider of 4
    c_if.seed = 16'd2; c_if.load_a = 1; tick();
    c_if.load_a = 0; c_if.seed = 16'd1; c_if.load_b = 1; tick();
    c_if.load_b = 0; c_if.start = 1; tick();
    c_if.start = 0;
    tick(); tick(); tick();
    chk("c_idx_e3", 32'(c_if.index), 1);
    tick();
    chk("c_idx_e4", 32'(c_if.index), 2);
    c_if.read_addr = 4'd2; #1;
    chk("c_term2", 32'(c_if.read_data), 3);
    chk("c_busy", 32'(c_if.busy), 1);
    n = 4;
    while (!c_if.done && n < 200) begin
      tick(); n++;
      if (!c_if.done && c_if.busy !== 1'b1) chk("c_busy_run", 32'(c_if.busy), 1);
    end
    chk("c_steps", 32'(n), 56);
    chk("c_busy_done", 32'(c_if.busy), 0);
    c_if.read_addr = 4'd5; #1;
    chk("c_term5", 32'(c_if.read_data), 11);

    // Manual stepping
    a_if.step_mode = 1;
    a_if.seed = 16'd0; a_if.load_a = 1; a_if.load_b = 0; tick();
    a_if.load_a = 0; a_if.seed = 16'd1; a_if.load_b = 1; tick();
    a_if.load_b = 0; a_if.start = 1; tick();
    a_if.start = 0;
    tick(); tick(); tick();
    chk("m_no_step", 32'(a_if.index), 1);
    a_if.step = 1; tick(); a_if.step = 0;
    chk("m_step1", 32'(a_if.index), 2);
    repeat (5) tick();
    chk("m_hold", 32'(a_if.index), 2);
    a_if.step = 1; tick(); a_if.step = 0;
    chk("m_step2", 32'(a_if.index), 3);
    tick(); tick();
    a_if.step = 1; tick(); a_if.step = 0;
    chk("m_step3", 32'(a_if.index), 4);

    // Back to divider pacing, then abort with a load at index 6
    a_if.step_mode = 0;
    tick(); tick();
    chk("x_idx6", 32'(a_if.index), 6);
    a_if.seed = 16'd5; a_if.load_a = 1; a_if.start = 1; tick();
    a_if.load_a = 0; a_if.start = 0;
    chk("x_busy", 32'(a_if.busy), 0);
    chk("x_done", 32'(a_if.done), 0);
    chk("x_idx0", 32'(a_if.index), 0);
    chk("x_cur5", 32'(a_if.current), 5);
    a_if.read_addr = 4'd0; #1; chk("x_term0", 32'(a_if.read_data), 5);
    a_if.read_addr = 4'd6; #1; chk("x_term6_kept", 32'(a_if.read_data), 8);
    tick();
    chk("x_idle_hold", 32'(a_if.index), 0);
    chk("x_idle_busy", 32'(a_if.busy), 0);

    // Asynchronous reset in the middle of a run
    a_if.start = 1; tick();
    a_if.start = 0;
    tick(); tick();
    chk("r_busy_pre", 32'(a_if.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_current", 32'(a_if.current), 0);
    chk("r_index",   32'(a_if.index), 0);
    chk("r_busy",    32'(a_if.busy), 0);
    chk("r_done",    32'(b_if.done), 0);
    chk("r_ovf",     32'(b_if.overflow), 0);
    a_if.read_addr = 4'd2; #1;
    chk("r_term2",   32'(a_if.read_data), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fib_sequencer.md
Name: fib_sequencer

Overview:
Parametrised, self-contained Fibonacci-style sequence generator with on-chip term storage. Two seed terms are loaded from switches. On Start, the block computes term[n] = term[n-1] + term[n-2] for n = 2 to DEPTH-1. Steps are paced by an internal tick divider or by a manual Step pulse. It replaces the hard-wired 16-term controller, adding configurable width, depth and pacing, overflow detection, saturation and a random-access read port for display logic.

Parameters:
WIDTH, 16, term width in bits (>=4)
DEPTH, 16, number of stored terms including both seeds (>=3); AW = clog2(DEPTH) local
TICK_DIV, 30000000, Clock cycles per automatic step (>=1; 1 = one step per cycle)

Ports:
Clock  input  1  system clock; all state changes on posedge
Reset  input  1  asynchronous active-low reset
LoadA  input  1  synchronous active-high strobe: term[0] <= Seed
LoadB  input  1  synchronous active-high strobe: term[1] <= Seed
Seed  input  WIDTH  seed value (zero-extended switch value)
Start  input  1  begin sequence generation (pulse)
StepMode  input  1  0 = divider-paced steps, 1 = manual Step pulses
Step  input  1  manual step strobe, used only when StepMode=1
Saturate  input  1  1 = clamp sums at all-ones, 0 = wrap modulo 2^WIDTH
ReadAddr  input  AW  term index for ReadData
ReadData  output  WIDTH  combinational term[ReadAddr]; 0 if ReadAddr >= DEPTH
Current  output  WIDTH  most recently written term (seed or computed)
Index  output  AW  index of the most recently written term
Busy  output  1  high in RUN
Done  output  1  high in DONE
Overflow  output  1  sticky: some sum in this run exceeded 2^WIDTH-1

Behaviour:
- Reset (async, Reset=0): state=IDLE; all terms, Current, Index, divider, Overflow = 0; Busy = Done = 0.
- States:
  - IDLE: waits for Start.
  - RUN: computes terms.
  - DONE: holds results.
- Loads (any state, highest priority after reset):
  - LoadA writes term[0]; LoadB writes term[1]; both asserted in one cycle write both.
  - Current/Index follow the load: LoadB wins if both are asserted.
  - Any load moves the state to IDLE (aborting RUN or leaving DONE), clears the divider, and suppresses Start and Step that cycle.
  - Terms 2..DEPTH-1 are not cleared by a load.
- Start:
  - Sampled in IDLE or DONE with no load in the same cycle: state becomes RUN, next index = 2, divider = 0, Overflow cleared.
  - Ignored in RUN.
- Step event in RUN:
  - StepMode=0: occurs on the edge where divider == TICK_DIV-1; divider then returns to 0, otherwise it increments.
  - StepMode=1: occurs on any edge with Step=1; divider is held at 0.
- On a step event:
  - sum = term[n-1] + term[n-2], computed at WIDTH+1 bits.
  - If carry is set: Overflow <= 1, and the stored value is all-ones when Saturate=1, else the low WIDTH bits.
  - term[n], Current and Index = n are updated on the same edge.
- When n == DEPTH-1 is written, state becomes DONE on that same edge.
- Timing with TICK_DIV=1: Start sampled at edge E0; term[k] is written at edge E(k-1); Done is high after edge E(DEPTH-2).
- Changing StepMode mid-RUN takes effect next cycle; the divider restarts from 0.
- Reset mid-RUN returns everything to reset values immediately.
- Busy/Done are decoded from the state register, with no extra latency.

Test Plan:
- WIDTH=16, DEPTH=16, TICK_DIV=1; LoadA with Seed=0, LoadB with Seed=1, then Start -> Done after 14 step edges; term[15]=610, ReadData@addr 10 = 55, Overflow=0.
- WIDTH=8, DEPTH=16, Saturate=0, seeds 0/1 -> term[13]=233, term[14]=121, term[15]=98, Overflow=1.
- Same as previous with Saturate=1 -> term[14]=255, term[15]=255, Overflow=1.
- TICK_DIV=4, seeds 2/1 (Lucas) -> one term every 4 cycles; term[2]=3 at edge E4, term[5]=11; Busy high until Done.
- StepMode=1, three Step pulses spaced irregularly -> Index steps to 2, 3, 4 only on pulse edges; no advance without a pulse.
- Mid-run: LoadA with Seed=5 at Index=6 -> state IDLE, Busy=0, term[0]=5, Start ignored that cycle. A later Reset low mid-run -> all outputs 0 asynchronously.
